dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Channel arbiter and request/grant sequencer for the four-channel DMA controller.
- Merges external DREQ pins with software requests and applies the mask register.
- Selects one channel under fixed or rotating priority and runs the HRQ/HLDA hold handshake with the CPU.
- Drives DACK and the selected channel number to the datapath and timing/control until timing/control reports end of service.

Parameters:
NUM_CH, 4, number of DMA channels (design supports exactly 4; parameter kept for package consistency)
CH_W, 2, width of channel number ($clog2(NUM_CH))

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
dreq  input  NUM_CH  raw DREQ pins
dreqSense  input  1  0: DREQ active-high; 1: DREQ active-low
dackSense  input  1  0: DACK active-low; 1: DACK active-high
requestRegister  input  NUM_CH  software request bits (always active-high)
maskRegister  input  NUM_CH  1 = channel masked
rotatingPriority  input  1  1: rotating priority; 0: fixed (ch0 highest)
hlda  input  1  hold acknowledge from CPU
serviceDone  input  1  single-cycle pulse from timing/control: granted channel finished (TC or end of block)
hrq  output  1  hold request to CPU
dack  output  NUM_CH  DMA acknowledge, polarity per dackSense
channelNo  output  CH_W  granted/pending channel number
grantValid  output  1  high while in GRANT (datapath may use channelNo)
pendingReq  output  NUM_CH  effective unmasked requests, for statusRegister[7:4]

Behaviour:
- Reset (async, rst=1): state=IDLE, hrq=0, grantValid=0, channelNo=0, priority pointer=0, DREQ sample register=0, dack=inactive level (all 1 if dackSense=0, all 0 if dackSense=1).
- DREQ sampling: dreq registered once per cycle. dreqEff = dreq_q XOR {NUM_CH{dreqSense}}.
- Effective request: effReq = (dreqEff | requestRegister) & ~maskRegister. pendingReq = effReq, combinational from registers.
- Priority:
  - The pointer holds the highest-priority channel index.
  - Winner = first set bit of effReq scanning pointer, pointer+1, ... modulo NUM_CH.
  - Fixed mode forces pointer=0 the cycle after rotatingPriority=0.
- States:
  - IDLE: if effReq != 0, latch winner into channelNo, hrq<=1, go to REQUEST. Otherwise stay.
  - REQUEST: hrq=1.
    - If hlda=1: go to GRANT, grantValid<=1, dack[channelNo]<=active. hlda wins over a simultaneous request drop.
    - Else if effReq[channelNo]=0: hrq<=0, go to IDLE, with no grant.
    - Else hold. The latched channel is not re-arbitrated while in REQUEST.
  - GRANT: channel locked, effReq changes ignored.
    - On serviceDone=1: go to IDLE, hrq<=0, grantValid<=0, dack<=inactive. If rotatingPriority=1, pointer<=channelNo+1 (mod NUM_CH, 3 wraps to 0).
    - On hlda=0 (abort) without serviceDone: same exit, pointer unchanged.
    - serviceDone and hlda drop together: treated as serviceDone.
- Latency: DREQ asserted before edge k is sampled at k, and hrq is high after edge k+1. hlda seen at edge m gives dack/grantValid high after edge m. serviceDone at edge n deasserts hrq/dack after edge n.
- hrq stays low for at least one full cycle (one IDLE cycle) between consecutive grants.
- Only one dack bit is ever active. dack bits are active only in GRANT.
- serviceDone outside GRANT is ignored.
- A dackSense change takes effect on the registered dack value the next cycle.
- rst mid-operation returns to the reset values immediately, regardless of state.

Decomposition:
- dma_pkg holds: enum arb_state_t {IDLE, REQUEST, GRANT}; NUM_CH and CH_W constants; the type for channel number.
- One combinational sub-module, dma_priority_encoder (inputs effReq and pointer; outputs winner and anyReq), keeps the rotating scan out of the FSM.

Test Plan:
- Fixed mode, dreqSense=0, dreq=4'b1010, mask=0 → hrq high 2 cycles later, channelNo=1; hlda=1 → dack=4'b1101 (dackSense=0), grantValid=1.
- Rotating mode: service ch1 (serviceDone pulse), then dreq=4'b1010 → next grant is ch3. After serving ch3, dreq=4'b0011 → ch0 (wrap).
- mask=4'b0010 with dreq=4'b0010 → hrq stays 0, pendingReq=0. requestRegister=4'b0100 with dreq=0 → ch2 granted.
- dreqSense=1, dreq pins=4'b1110 → effReq=4'b0001, ch0 granted. dackSense=1 → dack=4'b0001.
- REQUEST with ch2 pending, dreq2 dropped before hlda → hrq falls next cycle, no dack. Repeat with hlda and the drop in the same cycle → GRANT ch2.
- In GRANT (rotating, ch1): drop hlda → dack inactive, pointer stays 0. Separately, assert rst mid-GRANT → all outputs at reset values immediately.

Source files
------------

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA channel arbiter slice.
// Channel count is fixed at four; the constants exist so every file sizes buses the same way.
package dma_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = $clog2(NUM_CH);

   typedef logic [CH_W-1:0] chan_t;

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      GRANT
   } arb_state_t;

   function automatic logic [NUM_CH-1:0] chanOneHot(input chan_t ch);
      logic [NUM_CH-1:0] oneHot;
      oneHot     = '0;
      oneHot[ch] = 1'b1;
      return oneHot;
   endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bus between the DMA arbiter, the DREQ pins, the register file and the CPU hold logic.
// master = arbiter side, slave = everything around it.
interface dma_priority_arbiter_if;
   import dma_pkg::*;

   logic [NUM_CH-1:0] dreq;
   logic              dreqSense;
   logic              dackSense;
   logic [NUM_CH-1:0] requestRegister;
   logic [NUM_CH-1:0] maskRegister;
   logic              rotatingPriority;
   logic              hlda;
   logic              serviceDone;
   logic              hrq;
   logic [NUM_CH-1:0] dack;
   chan_t             channelNo;
   logic              grantValid;
   logic [NUM_CH-1:0] pendingReq;

   modport master (
      input  dreq, dreqSense, dackSense, requestRegister, maskRegister,
      input  rotatingPriority, hlda, serviceDone,
      output hrq, dack, channelNo, grantValid, pendingReq
   );

   modport slave (
      output dreq, dreqSense, dackSense, requestRegister, maskRegister,
      output rotatingPriority, hlda, serviceDone,
      input  hrq, dack, channelNo, grantValid, pendingReq
   );

endinterface

// File: rtl/dma_priority_arbiter_encoder.sv
// Rotating-priority scan: picks the first requesting channel starting at pointer and wrapping.
module dma_priority_encoder
   import dma_pkg::*;
(
   input  logic [NUM_CH-1:0] effReq,
   input  chan_t             pointer,
   output chan_t             winner,
   output logic              anyReq
);

   chan_t idx;

   // Scan from the far end back toward pointer so the nearest requester is written last.
   always_comb begin
      winner = pointer;
      idx    = pointer;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = pointer + chan_t'(i);
         if (effReq[idx]) winner = idx;
      end
   end

   assign anyReq = |effReq;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: merges DREQ/software requests, selects a channel and runs the HRQ/HLDA
// hold handshake, driving DACK and the channel number until timing/control ends service.
module dma_priority_arbiter
   import dma_pkg::*;
(
   input logic                    clk,
   input logic                    rst,
   dma_priority_arbiter_if.master bus
);

   logic [NUM_CH-1:0] dreqSampled;
   logic [NUM_CH-1:0] dreqEff;
   logic [NUM_CH-1:0] effReq;
   logic [NUM_CH-1:0] dackQ;
   logic [NUM_CH-1:0] dackNext;
   arb_state_t        state;
   arb_state_t        nextState;
   chan_t             channelNoQ;
   chan_t             channelNoNext;
   chan_t             pointer;
   chan_t             pointerNext;
   chan_t             winner;
   logic              anyReq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dreqSampled <= '0;
      else     dreqSampled <= bus.dreq;
   end

   assign dreqEff = dreqSampled ^ {NUM_CH{bus.dreqSense}};
   assign effReq  = (dreqEff | bus.requestRegister) & ~bus.maskRegister;

   dma_priority_encoder uEncoder (
      .effReq  (effReq),
      .pointer (pointer),
      .winner  (winner),
      .anyReq  (anyReq)
   );

   // dack is registered so a dackSense change shows up one cycle later, reset value included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         channelNoQ <= '0;
         pointer    <= '0;
         dackQ      <= {NUM_CH{~bus.dackSense}};
      end else begin
         state      <= nextState;
         channelNoQ <= channelNoNext;
         pointer    <= pointerNext;
         dackQ      <= dackNext;
      end
   end

   always_comb begin
      nextState     = state;
      channelNoNext = channelNoQ;
      pointerNext   = bus.rotatingPriority ? pointer : '0;
      case (state)
         IDLE: begin
            if (anyReq) begin
               nextState     = REQUEST;
               channelNoNext = winner;
            end
         end
         REQUEST: begin
            if (bus.hlda)                   nextState = GRANT;
            else if (!effReq[channelNoQ])   nextState = IDLE;
         end
         GRANT: begin
            // serviceDone outranks a simultaneous hlda drop so the pointer still advances.
            if (bus.serviceDone) begin
               nextState = IDLE;
               if (bus.rotatingPriority) pointerNext = chan_t'(channelNoQ + 1'b1);
            end else if (!bus.hlda) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.hrq        = (state != IDLE);
      bus.grantValid = (state == GRANT);
      dackNext       = ((nextState == GRANT) ? chanOneHot(channelNoQ) : '0)
                       ^ {NUM_CH{~bus.dackSense}};
   end

   assign bus.dack       = dackQ;
   assign bus.channelNo  = channelNoQ;
   assign bus.pendingReq = effReq;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration and hold-handshake rules.
module tb_dma_priority_arbiter;
   import dma_pkg::*;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   dma_priority_arbiter_if bus();

   dma_priority_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 waiting for hlda, 2 granted.
   int         mPhase;
   int         mChan;
   int         mPtr;
   logic [3:0] mDreqQ;
   logic [3:0] mDack;
   logic       mDackSense;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] mEff();
      logic [3:0] pins;
      pins = mDreqQ ^ {4{bus.dreqSense}};
      return (pins | bus.requestRegister) & ~bus.maskRegister;
   endfunction

   function automatic int mWinner(input logic [3:0] req, input int ptr);
      for (int k = 0; k < 4; k++)
         if (req[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic modelReset();
      mPhase     = 0;
      mChan      = 0;
      mPtr       = 0;
      mDreqQ     = 4'b0;
      mDackSense = bus.dackSense;
      mDack      = {4{~bus.dackSense}};
   endtask

   task automatic modelStep();
      logic [3:0] eff;
      int         nPtr;
      eff  = mEff();
      nPtr = bus.rotatingPriority ? mPtr : 0;
      case (mPhase)
         0: if (eff != 4'b0) begin
               mPhase = 1;
               mChan  = mWinner(eff, mPtr);
            end
         1: if (bus.hlda) mPhase = 2;
            else if (!eff[mChan]) mPhase = 0;
         default: if (bus.serviceDone) begin
               mPhase = 0;
               if (bus.rotatingPriority) nPtr = (mChan + 1) % 4;
            end else if (!bus.hlda) begin
               mPhase = 0;
            end
      endcase
      mPtr       = nPtr;
      mDreqQ     = bus.dreq;
      mDackSense = bus.dackSense;
      mDack      = ((mPhase == 2) ? (4'b0001 << mChan) : 4'b0000) ^ {4{~bus.dackSense}};
   endtask

   task automatic compareAll();
      logic [3:0] active;
      checkVal("hrq",        32'(bus.hrq),        32'(mPhase != 0));
      checkVal("grantValid", 32'(bus.grantValid), 32'(mPhase == 2));
      checkVal("channelNo",  32'(bus.channelNo),  32'(mChan));
      checkVal("dack",       32'(bus.dack),       32'(mDack));
      checkVal("pendingReq", 32'(bus.pendingReq), 32'(mEff()));
      active = bus.dack ^ {4{~mDackSense}};
      checkVal("dackOneHot", 32'($countones(active) <= 1), 32'(1));
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
   endtask

   task automatic asyncReset(input string tag);
      #2 rst = 1'b1;
      #1 modelReset();
      compareAll();
      checkVal({tag, ".hrq"},   32'(bus.hrq),        32'(0));
      checkVal({tag, ".gv"},    32'(bus.grantValid), 32'(0));
      checkVal({tag, ".ch"},    32'(bus.channelNo),  32'(0));
      checkVal({tag, ".dack"},  32'(bus.dack),       32'({4{~bus.dackSense}}));
      #1 rst = 1'b0;
   endtask

   task automatic waitHrq(input string tag);
      for (int i = 0; i < 4 && !bus.hrq; i++) tick();
      checkVal({tag, ".hrqRise"}, 32'(bus.hrq), 32'(1));
   endtask

   task automatic grantCycle(input logic [3:0] dOn, input logic [3:0] dOff,
                             input logic [3:0] rOn, input int expCh, input string tag);
      bus.dreq            = dOn;
      bus.requestRegister = rOn;
      waitHrq(tag);
      checkVal({tag, ".ch"}, 32'(bus.channelNo), 32'(expCh));
      bus.hlda = 1'b1;
      tick();
      checkVal({tag, ".gv"},   32'(bus.grantValid), 32'(1));
      checkVal({tag, ".dack"}, 32'(bus.dack), 32'((4'b0001 << expCh) ^ {4{~bus.dackSense}}));
      bus.dreq            = dOff;
      bus.requestRegister = 4'b0;
      bus.serviceDone     = 1'b1;
      tick();
      checkVal({tag, ".hrqFall"}, 32'(bus.hrq), 32'(0));
      bus.serviceDone = 1'b0;
      bus.hlda        = 1'b0;
      tick();
      tick();
   endtask

   task automatic setSenses(input logic dS, input logic kS);
      bus.maskRegister = 4'hF;
      bus.dreq         = {4{dS}};
      bus.dreqSense    = dS;
      bus.dackSense    = kS;
      tick();
      checkVal("senseDack", 32'(bus.dack), 32'({4{~kS}}));
      tick();
      bus.maskRegister = 4'h0;
      tick();
   endtask

   initial begin
      rst                  = 1'b1;
      bus.dreq             = 4'b0;
      bus.dreqSense        = 1'b0;
      bus.dackSense        = 1'b0;
      bus.requestRegister  = 4'b0;
      bus.maskRegister     = 4'b0;
      bus.rotatingPriority = 1'b0;
      bus.hlda             = 1'b0;
      bus.serviceDone      = 1'b0;
      @(posedge clk);
      #1 modelReset();
      compareAll();
      checkVal("rst.hrq",  32'(bus.hrq),        32'(0));
      checkVal("rst.dack", 32'(bus.dack),       32'(4'hF));
      checkVal("rst.ch",   32'(bus.channelNo),  32'(0));
      checkVal("rst.gv",   32'(bus.grantValid), 32'(0));
      @(negedge clk) rst = 1'b0;

      // Fixed priority, then rotating with wrap
      grantCycle(4'b1010, 4'b0000, 4'b0000, 1, "fixed");
      bus.rotatingPriority = 1'b1;
      tick();
      grantCycle(4'b0010, 4'b0000, 4'b0000, 1, "rot1");
      grantCycle(4'b1010, 4'b0000, 4'b0000, 3, "rot3");
      grantCycle(4'b0011, 4'b0000, 4'b0000, 0, "rotWrap");

      // Mask suppresses a request; software request alone is granted
      bus.rotatingPriority = 1'b0;
      bus.maskRegister     = 4'b0010;
      bus.dreq             = 4'b0010;
      repeat (3) tick();
      checkVal("masked.hrq",  32'(bus.hrq),        32'(0));
      checkVal("masked.pend", 32'(bus.pendingReq), 32'(0));
      bus.dreq = 4'b0000;
      tick();
      bus.maskRegister = 4'b0000;
      grantCycle(4'b0000, 4'b0000, 4'b0100, 2, "swReq");

      // Active-low DREQ and active-high DACK
      setSenses(1'b1, 1'b1);
      grantCycle(4'b1110, 4'b1111, 4'b0000, 0, "lowSense");
      setSenses(1'b0, 1'b0);

      // Request withdrawn before hlda, then withdrawn in the same cycle as hlda
      bus.dreq = 4'b0100;
      waitHrq("drop");
      checkVal("drop.ch", 32'(bus.channelNo), 32'(2));
      bus.dreq = 4'b0000;
      tick();
      tick();
      checkVal("drop.hrq",  32'(bus.hrq),        32'(0));
      checkVal("drop.gv",   32'(bus.grantValid), 32'(0));
      checkVal("drop.dack", 32'(bus.dack),       32'(4'hF));
      tick();
      bus.dreq = 4'b0100;
      waitHrq("race");
      bus.dreq = 4'b0000;
      bus.hlda = 1'b1;
      tick();
      checkVal("race.gv", 32'(bus.grantValid), 32'(1));
      checkVal("race.ch", 32'(bus.channelNo),  32'(2));
      bus.serviceDone = 1'b1;
      tick();
      bus.serviceDone = 1'b0;
      bus.hlda        = 1'b0;
      tick();
      tick();

      // hlda abort in rotating mode leaves the pointer alone
      bus.rotatingPriority = 1'b1;
      tick();
      bus.dreq = 4'b0010;
      waitHrq("abort");
      bus.hlda = 1'b1;
      tick();
      checkVal("abort.gv", 32'(bus.grantValid), 32'(1));
      bus.dreq = 4'b0000;
      bus.hlda = 1'b0;
      tick();
      checkVal("abort.hrq",  32'(bus.hrq),  32'(0));
      checkVal("abort.dack", 32'(bus.dack), 32'(4'hF));
      tick();
      tick();
      grantCycle(4'b1001, 4'b0000, 4'b0000, 0, "ptrKept");

      // Reset in the middle of a grant
      bus.dreq = 4'b0100;
      waitHrq("midRst");
      bus.hlda = 1'b1;
      tick();
      checkVal("midRst.gv", 32'(bus.grantValid), 32'(1));
      asyncReset("midRst");
      bus.hlda = 1'b0;
      bus.dreq = 4'b0000;
      tick();
      tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bus.dreq            = 4'($urandom);
         bus.requestRegister = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
         bus.maskRegister    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         if ($urandom_range(0, 49) == 0) bus.rotatingPriority = ~bus.rotatingPriority;
         if ($urandom_range(0, 99) == 0) bus.dreqSense = ~bus.dreqSense;
         if ($urandom_range(0, 99) == 0) bus.dackSense = ~bus.dackSense;
         bus.hlda        = (mPhase != 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
         bus.serviceDone = ($urandom_range(0, 5) == 0);
         tick();
         if ($urandom_range(0, 199) == 0) asyncReset("rndRst");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
